matrix_dma_bridge: RTL

//  Downstream bus stage for the matrix accelerator: services its single-word DMA req/ack port and

---
 rtl/matrix_dma_bridge_if.sv | 39 +++
 rtl/matrix_dma_bridge.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_dma_bridge_if.sv
// Bus bundle for matrix_dma_bridge: the accelerator's single-word DMA
// req/ack port and the Wishbone classic master port.
// The master modport is the bridge's view; the slave modport is the
// environment's view (accelerator plus system memory).
interface matrix_dma_bridge_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          dma_req;
    logic [AW-1:0] dma_addr;
    logic          dma_we;
    logic [DW-1:0] dma_wdata;
    logic [DW-1:0] dma_rdata;
    logic          dma_ack;

    logic [AW-1:0] wbm_adr_o;
    logic [DW-1:0] wbm_dat_o;
    logic [DW-1:0] wbm_dat_i;
    logic          wbm_we_o;
    logic [3:0]    wbm_sel_o;
    logic          wbm_cyc_o;
    logic          wbm_stb_o;
    logic          wbm_ack_i;
    logic          wbm_err_i;

    modport master (
        input  dma_req, dma_addr, dma_we, dma_wdata,
        output dma_rdata, dma_ack,
        output wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_cyc_o, wbm_stb_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i
    );

    modport slave (
        output dma_req, dma_addr, dma_we, dma_wdata,
        input  dma_rdata, dma_ack,
        input  wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_cyc_o, wbm_stb_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i
    );
endinterface

// File: rtl/matrix_dma_bridge.sv
// matrix_dma_bridge: turns each single-word DMA request from the matrix
// accelerator into one Wishbone classic master cycle, returns read data or
// write completion on a one-cycle dma_ack, and records bus errors, timeouts
// and misaligned addresses in a sticky error flag.
// Optional feature macro: DMA_BRIDGE_STATS_EN adds rd_count/wr_count outputs
// counting completed non-error reads and writes.
module matrix_dma_bridge #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clk,
    input  logic                reset,
    matrix_dma_bridge_if.master bus,
    output logic                busy,
    output logic                err,
    output logic [AW-1:0]       err_addr,
    input  logic                err_clr
`ifdef DMA_BRIDGE_STATS_EN
    ,
    output logic [15:0]         rd_count,
    output logic [15:0]         wr_count
`endif
);

    // Counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int            CW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t        state_r;
    logic [CW-1:0] cyc_cnt_r;
    logic [AW-1:0] adr_r;
    logic [DW-1:0] dat_r;
    logic          we_r;
    logic          cyc_r;
    logic [3:0]    sel_r;
    logic [DW-1:0] rdata_r;
    logic          ack_r;
    logic          busy_r;
    logic          err_r;
    logic [AW-1:0] err_addr_r;
    logic          err_live_s;

    // Error flag as seen by this cycle's capture: a same-cycle clear lets a new error re-capture.
    always_comb begin
        err_live_s = 1'b0;
        if (err_clr) begin
            err_live_s = 1'b0;
        end else begin
            err_live_s = err_r;
        end
    end

    // Request sequencer: IDLE -> BUS -> RESP -> HOLD -> IDLE with all bus/DMA outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            cyc_cnt_r  <= '0;
            adr_r      <= '0;
            dat_r      <= '0;
            we_r       <= 1'b0;
            cyc_r      <= 1'b0;
            sel_r      <= 4'h0;
            rdata_r    <= '0;
            ack_r      <= 1'b0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
            err_addr_r <= '0;
        end else begin
            ack_r <= 1'b0;
            if (err_clr) begin
                err_r      <= 1'b0;
                err_addr_r <= '0;
            end
            case (state_r)
                IDLE: begin
                    if (bus.dma_req) begin
                        busy_r <= 1'b1;
                        if (bus.dma_addr[1:0] == 2'b00) begin
                            adr_r     <= bus.dma_addr;
                            dat_r     <= bus.dma_wdata;
                            we_r      <= bus.dma_we;
                            cyc_r     <= 1'b1;
                            sel_r     <= 4'hF;
                            cyc_cnt_r <= '0;
                            state_r   <= BUS;
                        end else begin
                            // Misaligned: never reaches the bus, completes as an error.
                            rdata_r <= '0;
                            err_r   <= 1'b1;
                            if (!err_live_s) begin
                                err_addr_r <= bus.dma_addr;
                            end
                            ack_r   <= 1'b1;
                            state_r <= RESP;
                        end
                    end
                end
                BUS: begin
                    // Slave error beats a simultaneous ack; a real ack beats the timeout.
                    if (bus.wbm_err_i || (!bus.wbm_ack_i && (cyc_cnt_r == CNT_LAST))) begin
                        cyc_r   <= 1'b0;
                        sel_r   <= 4'h0;
                        rdata_r <= '0;
                        err_r   <= 1'b1;
                        if (!err_live_s) begin
                            err_addr_r <= adr_r;
                        end
                        ack_r   <= 1'b1;
                        state_r <= RESP;
                    end else if (bus.wbm_ack_i) begin
                        cyc_r <= 1'b0;
                        sel_r <= 4'h0;
                        if (!we_r) begin
                            rdata_r <= bus.wbm_dat_i;
                        end
                        ack_r   <= 1'b1;
                        state_r <= RESP;
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                RESP: begin
                    state_r <= HOLD;
                end
                HOLD: begin
                    // Requester gets one cycle to drop or change dma_req.
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    cyc_r   <= 1'b0;
                    sel_r   <= 4'h0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.wbm_adr_o = adr_r;
    assign bus.wbm_dat_o = dat_r;
    assign bus.wbm_we_o  = we_r;
    assign bus.wbm_sel_o = sel_r;
    assign bus.wbm_cyc_o = cyc_r;
    assign bus.wbm_stb_o = cyc_r;
    assign bus.dma_rdata = rdata_r;
    assign bus.dma_ack   = ack_r;
    assign busy          = busy_r;
    assign err           = err_r;
    assign err_addr      = err_addr_r;

`ifdef DMA_BRIDGE_STATS_EN
    logic        rd_done_s;
    logic        wr_done_s;
    logic [15:0] rd_count_r;
    logic [15:0] wr_count_r;

    // Successful completion strobes, asserted on the edge that enters RESP.
    always_comb begin
        rd_done_s = 1'b0;
        wr_done_s = 1'b0;
        if ((state_r == BUS) && bus.wbm_ack_i && !bus.wbm_err_i) begin
            rd_done_s = !we_r;
            wr_done_s = we_r;
        end else begin
            rd_done_s = 1'b0;
            wr_done_s = 1'b0;
        end
    end

    // Saturating completion counters, cleared together with the error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count_r <= 16'h0000;
            wr_count_r <= 16'h0000;
        end else if (err_clr) begin
            rd_count_r <= 16'h0000;
            wr_count_r <= 16'h0000;
        end else begin
            if (rd_done_s && (rd_count_r != 16'hFFFF)) begin
                rd_count_r <= rd_count_r + 16'h0001;
            end
            if (wr_done_s && (wr_count_r != 16'hFFFF)) begin
                wr_count_r <= wr_count_r + 16'h0001;
            end
        end
    end

    assign rd_count = rd_count_r;
    assign wr_count = wr_count_r;
`endif

endmodule
